// File: rtl/video_timing_gen_pkg.sv
// Shared types, default raster constants and helpers for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        logic pal;
        logic scandouble;
    } mode_t;

    localparam int DEF_CE_DIV       = 8;
    localparam int DEF_H_ACTIVE     = 384;
    localparam int DEF_H_TOTAL      = 456;
    localparam int DEF_H_SYNC_START = 400;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_ACTIVE     = 240;
    localparam int DEF_V_TOTAL_NTSC = 262;
    localparam int DEF_V_TOTAL_PAL  = 312;
    localparam int DEF_V_SYNC_START = 248;
    localparam int DEF_V_SYNC_LEN   = 3;

    function automatic int v_total(input logic pal, input int ntsc_lines, input int pal_lines);
        return pal ? pal_lines : ntsc_lines;
    endfunction

endpackage

// File: rtl/video_timing_gen_ce_divider.sv
// Pixel clock-enable divider: one-cycle ce every CE_DIV clocks, or CE_DIV/2 when half is set.
module ce_divider #(
    parameter int CE_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic half,
    output logic ce
);

    localparam int DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] LAST_FULL = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] LAST_HALF = DW'(CE_DIV / 2 - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        ce    = (div_q == (half ? LAST_HALF : LAST_FULL));
        div_d = ce ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with frame-safe mode switching and scandoubling.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV       = DEF_CE_DIV,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
    parameter int V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter int HW           = 9,
    parameter int VW           = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pal,
    input  logic          scandouble,
    output logic          ce_pix,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          dbl_line,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_RESET = VW'(V_TOTAL_NTSC - 1);
    // Decode constants carry one spare bit so START+LEN never wraps.
    localparam logic [HW:0] H_ACT_X = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_LO   = (HW+1)'(H_SYNC_START);
    localparam logic [HW:0] HS_HI   = (HW+1)'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VW:0] V_ACT_X = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_LO   = (VW+1)'(V_SYNC_START);
    localparam logic [VW:0] VS_HI   = (VW+1)'(V_SYNC_START + V_SYNC_LEN);

    mode_t         mode_q;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d, v_last;
    logic          dbl_q, dbl_d;
    logic          ce, entry;
    logic [HW:0]   h_x;
    logic [VW:0]   v_x;

    logic          ce_pix_q, dbl_line_q, hblank_q, vblank_q, hsync_q, vsync_q, frame_start_q;
    logic [HW-1:0] hcount_q;
    logic [VW-1:0] vcount_q;

    ce_divider #(.CE_DIV(CE_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .half  (mode_q.scandouble),
        .ce    (ce)
    );

    // Next-state counters; only committed on a ce edge.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        dbl_d  = dbl_q;
        v_last = VW'(v_total(mode_q.pal, V_TOTAL_NTSC, V_TOTAL_PAL) - 1);
        if (h_q == H_LAST) begin
            h_d   = '0;
            dbl_d = mode_q.scandouble ? ~dbl_q : 1'b0;
            if (!mode_q.scandouble || dbl_q)
                v_d = (v_q == v_last) ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end
        entry = (h_d == '0) && (v_d == '0) && !dbl_d;
        h_x   = {1'b0, h_d};
        v_x   = {1'b0, v_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= H_LAST;
            v_q           <= V_RESET;
            dbl_q         <= 1'b1;
            mode_q        <= '0;
            ce_pix_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            dbl_line_q    <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            ce_pix_q      <= ce;
            frame_start_q <= ce && entry;
            if (ce) begin
                h_q        <= h_d;
                v_q        <= v_d;
                dbl_q      <= dbl_d;
                hcount_q   <= h_d;
                vcount_q   <= v_d;
                dbl_line_q <= dbl_d;
                hblank_q   <= (h_x >= H_ACT_X);
                vblank_q   <= (v_x >= V_ACT_X);
                hsync_q    <= (h_x >= HS_LO) && (h_x < HS_HI);
                vsync_q    <= (v_x >= VS_LO) && (v_x < VS_HI);
                // Mode changes take effect only as the raster re-enters the origin.
                if (entry) mode_q <= {pal, scandouble};
            end
        end
    end

    assign ce_pix      = ce_pix_q;
    assign frame_start = frame_start_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign dbl_line    = dbl_line_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-size instance and a tiny raster instance, each scoreboarded per pixel.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b, pal_b, sd_b, rst_s, pal_s, sd_s;
    logic       ce_b, dbl_b, hb_b, vb_b, hs_b, vs_b, fs_b;
    logic       ce_s, dbl_s, hb_s, vb_s, hs_s, vs_s, fs_s;
    logic [8:0] hc_b, vc_b, hc_s, vc_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mark_b = 0, mark_s = 0, last_fs_s = -1;

    // Entry: {gap[7:0], fs, vs, hs, vb, hb, dbl, v[8:0], h[8:0]}
    logic [31:0] exp_b_q[$];
    logic [31:0] exp_s_q[$];
    int          fp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    video_timing_gen dut_big (
        .clk(clk), .reset(rst_b), .pal(pal_b), .scandouble(sd_b),
        .ce_pix(ce_b), .hcount(hc_b), .vcount(vc_b), .dbl_line(dbl_b),
        .HBlank(hb_b), .VBlank(vb_b), .HSync(hs_b), .VSync(vs_b), .frame_start(fs_b)
    );

    video_timing_gen #(
        .CE_DIV(2), .H_ACTIVE(6), .H_TOTAL(10), .H_SYNC_START(7), .H_SYNC_LEN(2),
        .V_ACTIVE(2), .V_TOTAL_NTSC(4), .V_TOTAL_PAL(6), .V_SYNC_START(2), .V_SYNC_LEN(2)
    ) dut_small (
        .clk(clk), .reset(rst_s), .pal(pal_s), .scandouble(sd_s),
        .ce_pix(ce_s), .hcount(hc_s), .vcount(vc_s), .dbl_line(dbl_s),
        .HBlank(hb_s), .VBlank(vb_s), .HSync(hs_s), .VSync(vs_s), .frame_start(fs_s)
    );

    function automatic logic [31:0] pack(input int gap, input logic fs, input logic vs, input logic hs,
                                         input logic vb, input logic hb, input logic dbl,
                                         input int v, input int h);
        return {gap[7:0], fs, vs, hs, vb, hb, dbl, v[8:0], h[8:0]};
    endfunction

    // Default raster: blank from 384, sync [400,432), line v < 240 so no vertical flags.
    task automatic push_line_b(input int v, input int hmax);
        for (int h = 0; h <= hmax; h++)
            exp_b_q.push_back(pack(8, (v == 0 && h == 0), 1'b0, (h >= 400 && h < 432),
                                   1'b0, (h >= 384), 1'b0, v, h));
    endtask

    // Tiny raster: 10 px/line (blank 6.., sync 7..8), 4 or 6 lines (blank 2.., sync 2..3).
    task automatic push_frame_s(input bit pal, input bit sd, input int gap0);
        int  vt = pal ? 6 : 4;
        bit  first = 1'b1;
        int  g;
        for (int v = 0; v < vt; v++)
            for (int d = 0; d <= (sd ? 1 : 0); d++)
                for (int h = 0; h < 10; h++) begin
                    g = (first && gap0 != 0) ? gap0 : (sd ? 1 : 2);
                    first = 1'b0;
                    exp_s_q.push_back(pack(g, (v == 0 && d == 0 && h == 0), (v >= 2 && v < 4),
                                           (h >= 7 && h < 9), (v >= 2), (h >= 6), d[0], v, h));
                end
    endtask

    task automatic check_zero(input string name, input logic [31:0] act);
        checks++;
        if (act !== 32'd0) begin
            errors++;
            $display("FAIL %s: actual outputs %h, required 00000000", name, act);
        end
    endtask

    task automatic wait_empty(input bit big, input int budget);
        int n = 0;
        while (((big ? exp_b_q.size() : exp_s_q.size()) > 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if ((big ? exp_b_q.size() : exp_s_q.size()) > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual %0d pixels outstanding, required 0",
                     big ? "big" : "small", big ? exp_b_q.size() : exp_s_q.size());
            if (big) exp_b_q.delete();
            else begin exp_s_q.delete(); fp_q.delete(); end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] act, exp;
        if (ce_b) begin
            act = pack(cyc - mark_b, fs_b, vs_b, hs_b, vb_b, hb_b, dbl_b, int'(vc_b), int'(hc_b));
            mark_b = cyc;
            if (exp_b_q.size() > 0) begin
                exp = exp_b_q.pop_front();
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL big_pixel: actual %h required %h (expected h=%0d v=%0d)",
                             act, exp, exp[8:0], exp[17:9]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] act, exp;
        int          p;
        if (ce_s) begin
            act = pack(cyc - mark_s, fs_s, vs_s, hs_s, vb_s, hb_s, dbl_s, int'(vc_s), int'(hc_s));
            mark_s = cyc;
            if (exp_s_q.size() > 0) begin
                exp = exp_s_q.pop_front();
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL small_pixel: actual %h required %h (expected h=%0d v=%0d dbl=%0d)",
                             act, exp, exp[8:0], exp[17:9], exp[18]);
                end
            end
        end
        if (fs_s) begin
            if (last_fs_s >= 0 && fp_q.size() > 0) begin
                p = fp_q.pop_front();
                checks++;
                if (cyc - last_fs_s != p) begin
                    errors++;
                    $display("FAIL small_frame_period: actual %0d clks, required %0d", cyc - last_fs_s, p);
                end
            end
            last_fs_s = cyc;
        end
    end

    initial begin
        rst_b = 1'b1; pal_b = 1'b0; sd_b = 1'b0;
        rst_s = 1'b1; pal_s = 1'b0; sd_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("big_reset", {ce_b, dbl_b, hb_b, vb_b, hs_b, vs_b, fs_b, vc_b, hc_b});
        check_zero("small_reset", {ce_s, dbl_s, hb_s, vb_s, hs_s, vs_s, fs_s, vc_s, hc_s});

        // Default raster: full line 0 then line 1 up to hcount 200.
        push_line_b(0, 455);
        push_line_b(1, 200);
        #1 rst_b = 1'b0; mark_b = cyc;
        wait_empty(1'b1, 6000);

        // One-clock reset right after pixel (200,1).
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("big_midframe_reset", {ce_b, dbl_b, hb_b, vb_b, hs_b, vs_b, fs_b, vc_b, hc_b});
        push_line_b(0, 3);
        #1 rst_b = 1'b0; mark_b = cyc;
        wait_empty(1'b1, 100);

        // Tiny raster, NTSC; pal raised mid-way through frame 1 only affects frame 2 on.
        push_frame_s(1'b0, 1'b0, 0);
        push_frame_s(1'b0, 1'b0, 0);
        push_frame_s(1'b1, 1'b0, 0);
        push_frame_s(1'b1, 1'b0, 0);
        fp_q.push_back(80);
        fp_q.push_back(80);
        fp_q.push_back(120);
        last_fs_s = -1;
        rst_s = 1'b0; mark_s = cyc;
        repeat (125) @(posedge clk);
        #1 pal_s = 1'b1;
        wait_empty(1'b0, 1000);

        // Scandouble from reset: first ce at the full divider, then every clock.
        rst_s = 1'b1; pal_s = 1'b0; sd_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("small_reset_sd", {ce_s, dbl_s, hb_s, vb_s, hs_s, vs_s, fs_s, vc_s, hc_s});
        push_frame_s(1'b0, 1'b1, 2);
        push_frame_s(1'b0, 1'b1, 0);
        fp_q.push_back(80);
        last_fs_s = -1;
        #1 rst_s = 1'b0; mark_s = cyc;
        wait_empty(1'b0, 500);

        // Reset dropped into the middle of a scandoubled frame.
        repeat (37) @(posedge clk);
        #1 rst_s = 1'b1; sd_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("small_midframe_reset", {ce_s, dbl_s, hb_s, vb_s, hs_s, vs_s, fs_s, vc_s, hc_s});
        push_frame_s(1'b0, 1'b0, 0);
        last_fs_s = -1;
        #1 rst_s = 1'b0; mark_s = cyc;
        wait_empty(1'b0, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
